// File: rtl/alu_op_sequencer.sv
// Command initiator for the registered ALU units: issues one operation at a time,
// waits out the unit latency, captures the result and hands it back over valid/ready.
module alu_op_sequencer #(
   parameter int WIDTH   = 16,
   parameter int OPW     = 4,
   parameter int NUM_OPS = 8,
   parameter int LATENCY = 1,
   parameter int CNTW    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OPW-1:0]   cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [OPW-1:0]   alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [OPW-1:0]   res_op,
   output logic             res_err,
   output logic [CNTW-1:0]  ops_done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0]      LAT_CNT = 4'(LATENCY);
   localparam logic [CNTW-1:0] ONE_CNT = {{(CNTW-1){1'b0}}, 1'b1};

   logic [1:0]       state_q,    state_d;
   logic [3:0]       cnt_q,      cnt_d;
   logic [OPW-1:0]   alu_op_q,   alu_op_d;
   logic [WIDTH-1:0] alu_a_q,    alu_a_d;
   logic [WIDTH-1:0] alu_b_q,    alu_b_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic [OPW-1:0]   res_op_q,   res_op_d;
   logic             res_err_q,  res_err_d;
   logic [CNTW-1:0]  ops_done_q, ops_done_d;

   function automatic logic op_legal(input logic [OPW-1:0] op);
      return int'(op) < NUM_OPS;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      alu_op_d   = alu_op_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      res_data_d = res_data_q;
      res_op_d   = res_op_q;
      res_err_d  = res_err_q;
      ops_done_d = ops_done_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               alu_op_d = cmd_op;
               alu_a_d  = cmd_a;
               alu_b_d  = cmd_b;
               res_op_d = cmd_op;
               if (op_legal(cmd_op)) begin
                  cnt_d   = LAT_CNT;
                  state_d = S_WAIT;
               end else begin
                  // Illegal opcodes never reach the units; report immediately.
                  res_data_d = '0;
                  res_err_d  = 1'b1;
                  state_d    = S_DONE;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               res_data_d = alu_result;
               res_err_d  = 1'b0;
               state_d    = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               ops_done_d = ops_done_q + ONE_CNT;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         alu_op_q   <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         res_data_q <= '0;
         res_op_q   <= '0;
         res_err_q  <= 1'b0;
         ops_done_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         alu_op_q   <= alu_op_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         res_data_q <= res_data_d;
         res_op_q   <= res_op_d;
         res_err_q  <= res_err_d;
         ops_done_q <= ops_done_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign res_valid = (state_q == S_DONE);
   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign res_data  = res_data_q;
   assign res_op    = res_op_q;
   assign res_err   = res_err_q;
   assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a registered single-stage ALU attached;
// results are scoreboarded by a monitor that fires on every result handshake.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = '0;
   logic [15:0] cmd_a = '0;
   logic [15:0] cmd_b = '0;
   logic [3:0]  alu_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_result = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;
   logic [3:0]  res_op;
   logic        res_err;
   logic [3:0]  ops_done;

   alu_op_sequencer #(.WIDTH(16), .OPW(4), .NUM_OPS(8), .LATENCY(1), .CNTW(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_op(res_op), .res_err(res_err),
      .ops_done(ops_done)
   );

   always #5 clk = ~clk;

   // Attached ALU bank: one register stage, result muxed by alu_op.
   always @(posedge clk) begin
      case (alu_op)
         4'd0: alu_result <= ~alu_a;
         4'd1: alu_result <= alu_a & alu_b;
         4'd2: alu_result <= alu_a | alu_b;
         4'd3: alu_result <= alu_a ^ alu_b;
         4'd4: alu_result <= alu_a + alu_b;
         4'd5: alu_result <= alu_a - alu_b;
         4'd6: alu_result <= ~(alu_a & alu_b);
         default: alu_result <= alu_a;
      endcase
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  op;
      logic        e;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;
   logic [3:0] exp_done = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: sample on the falling edge, predict what the next rising edge does.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) chk("ops_done_track", 32'(ops_done), 32'(exp_done));
      if (rst) begin
         exp_q.delete();
         exp_done = '0;
      end else if (res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got data %0h with empty scoreboard", res_data);
         end else begin
            e = exp_q.pop_front();
            chk("res_data", 32'(res_data), 32'(e.d));
            chk("res_op", 32'(res_op), 32'(e.op));
            chk("res_err", 32'(res_err), 32'(e.e));
         end
         exp_done = exp_done + 4'd1;
      end
   end

   // All tasks are entered 1 time unit after a rising edge.
   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ed, input logic ee, input logic hold,
                        output int acc);
      int t = 0;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      while (!cmd_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!cmd_ready) begin
         chk("issue_timeout", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
         acc = -1;
      end else begin
         exp_q.push_back('{d: ed, op: op, e: ee});
         @(posedge clk); #1;
         acc = cyc;
         if (!hold) cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!cmd_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!cmd_ready) chk("idle_timeout", 32'(cmd_ready), 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   initial begin
      int acc0, acc1, acc2;
      do_reset();
      mon_en = 1'b1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_res_err", 32'(res_err), 32'd0);
      chk("rst_ops_done", 32'(ops_done), 32'd0);

      // Single NOT with exact timing
      res_ready = 1'b1;
      issue(4'd0, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0, acc0);
      chk("t1_alu_a_E0", 32'(alu_a), 32'h00FF);
      chk("t1_ready_E0", 32'(cmd_ready), 32'd0);
      chk("t1_valid_E0", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
      chk("t1_valid_E1", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
      chk("t1_valid_E2", 32'(res_valid), 32'd1);
      chk("t1_data_E2", 32'(res_data), 32'hFF00);
      chk("t1_err_E2", 32'(res_err), 32'd0);
      @(posedge clk); #1;
      chk("t1_ready_E3", 32'(cmd_ready), 32'd1);
      chk("t1_ops_done_E3", 32'(ops_done), 32'd1);
      issue(4'd3, 16'h5555, 16'h0FF0, 16'h5AA5, 1'b0, 1'b0, acc0);
      wait_idle();
      issue(4'd4, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, acc0);
      wait_idle();

      // Backpressure
      res_ready = 1'b0;
      issue(4'd0, 16'h1234, 16'h0000, 16'hEDCB, 1'b0, 1'b0, acc0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_data", 32'(res_data), 32'hEDCB);
         chk("bp_valid", 32'(res_valid), 32'd1);
         chk("bp_ready", 32'(cmd_ready), 32'd0);
         cmd_valid = (i == 1);
         cmd_op = 4'd0; cmd_a = 16'hFFFF;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      chk("bp_alu_a_hold", 32'(alu_a), 32'h1234);
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", 32'(res_valid), 32'd0);
      chk("bp_release_done", 32'(ops_done), 32'd4);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("bp_single_hs", 32'(ops_done), 32'd4);

      // Illegal opcode
      res_ready = 1'b0;
      issue(4'hF, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b0, acc0);
      chk("ill_alu_a", 32'(alu_a), 32'h1111);
      chk("ill_alu_op", 32'(alu_op), 32'hF);
      @(posedge clk); #1;
      chk("ill_valid", 32'(res_valid), 32'd1);
      chk("ill_err", 32'(res_err), 32'd1);
      chk("ill_data", 32'(res_data), 32'd0);
      chk("ill_op", 32'(res_op), 32'hF);
      res_ready = 1'b1;
      wait_idle();

      // Back-to-back, cmd_valid held
      issue(4'd0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1, acc0);
      issue(4'd0, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, acc1);
      issue(4'd0, 16'hA5A5, 16'h0000, 16'h5A5A, 1'b0, 1'b1, acc2);
      cmd_valid = 1'b0;
      chk("b2b_period1", 32'(acc1 - acc0), 32'd4);
      chk("b2b_period2", 32'(acc2 - acc1), 32'd4);
      wait_idle();

      // Reset mid-WAIT
      do_reset();
      issue(4'd1, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, acc0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("mid_rst_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
      chk("mid_rst_ops_done", 32'(ops_done), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("mid_rst_no_result", 32'(res_valid), 32'd0);
      end
      issue(4'd2, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, acc0);
      wait_idle();
      chk("mid_rst_next_done", 32'(ops_done), 32'd1);

      // Counter wrap with a 4-bit ops_done
      do_reset();
      for (int i = 0; i < 17; i++) begin
         logic [15:0] a;
         a = 16'(i * 16'h0101);
         issue(4'd0, a, 16'h0000, ~a, 1'b0, 1'b0, acc0);
         wait_idle();
         if (i == 14) chk("wrap_15", 32'(ops_done), 32'd15);
         if (i == 15) chk("wrap_0", 32'(ops_done), 32'd0);
         if (i == 16) chk("wrap_1", 32'(ops_done), 32'd1);
      end

      @(posedge clk); #1;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
